// File: rtl/uart_port_arbiter_if.sv
// uart_port_arbiter_if: requester and buffer signals of the UART port arbiter.
// master = requesters plus buffer model, slave = the arbiter itself.
interface uart_port_arbiter_if;
    logic        m0_rreq;
    logic [1:0]  m0_rsize;
    logic        m0_rdone;
    logic [31:0] m0_rdata;
    logic        m0_rerr;
    logic        m0_wreq;
    logic [1:0]  m0_wsize;
    logic [31:0] m0_wdata;
    logic        m0_wdone;
    logic        m0_werr;

    logic        m1_rreq;
    logic [1:0]  m1_rsize;
    logic        m1_rdone;
    logic [31:0] m1_rdata;
    logic        m1_rerr;
    logic        m1_wreq;
    logic [1:0]  m1_wsize;
    logic [31:0] m1_wdata;
    logic        m1_wdone;
    logic        m1_werr;

    logic        renable;
    logic [1:0]  rsize;
    logic [31:0] rdata;
    logic        rdone;
    logic        wenable;
    logic [1:0]  wsize;
    logic [31:0] wdata;
    logic        wdone;
    logic [1:0]  rgrant;
    logic [1:0]  wgrant;

    modport master (
        output m0_rreq, m0_rsize, m0_wreq, m0_wsize, m0_wdata,
        output m1_rreq, m1_rsize, m1_wreq, m1_wsize, m1_wdata,
        output rdata, rdone, wdone,
        input  m0_rdone, m0_rdata, m0_rerr, m0_wdone, m0_werr,
        input  m1_rdone, m1_rdata, m1_rerr, m1_wdone, m1_werr,
        input  renable, rsize, wenable, wsize, wdata, rgrant, wgrant
    );

    modport slave (
        input  m0_rreq, m0_rsize, m0_wreq, m0_wsize, m0_wdata,
        input  m1_rreq, m1_rsize, m1_wreq, m1_wsize, m1_wdata,
        input  rdata, rdone, wdone,
        output m0_rdone, m0_rdata, m0_rerr, m0_wdone, m0_werr,
        output m1_rdone, m1_rdata, m1_rerr, m1_wdone, m1_werr,
        output renable, rsize, wenable, wsize, wdata, rgrant, wgrant
    );
endinterface

// File: rtl/uart_port_arbiter.sv
// uart_port_arbiter: shares the UART buffer read/write ports between m0 and m1.
// Optional UART_ARB_FIXED_PRIO_EN: m0 always wins ties (no round-robin pointer).

module uart_arb_chan (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] size0,
    input  logic [1:0] size1,
    input  logic       bus_done,
    output logic       enable,
    output logic [1:0] size,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic       active
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0] state;
    logic [1:0] own_size;
    logic       legal;
    logic       pick;
    logic       finish;

    assign own_size = grant[1] ? size1 : size0;
    assign legal    = (own_size == 2'b00) || (own_size == 2'b11);
    assign finish   = ((state == ISSUE) && !legal) || ((state == WAIT) && bus_done);

`ifdef UART_ARB_FIXED_PRIO_EN
    assign pick = ~req[0];
`else
    logic last;

    assign pick = (&req) ? ~last : req[1];

    // Round-robin pointer: remembers which requester completed last (1 = m1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (finish)
            last <= grant[1];
    end
`endif

    // Channel FSM: grant in IDLE, one-cycle ISSUE, WAIT until the buffer answers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= pick ? 2'b10 : 2'b01;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (legal) begin
                        state <= WAIT;
                    end else begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                WAIT: begin
                    if (bus_done) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Buffer-side controls and requester completion pulses.
    always_comb begin
        active = ((state == ISSUE) && legal) || (state == WAIT);
        enable = (state == ISSUE) && legal;
        size   = active ? own_size : 2'b00;
        done   = finish ? grant : 2'b00;
        err    = ((state == ISSUE) && !legal) ? grant : 2'b00;
    end
endmodule

module uart_port_arbiter (
    input logic               clk,
    input logic               rst,
    uart_port_arbiter_if.slave bus
);
    logic [1:0] r_done;
    logic [1:0] r_err;
    logic       r_act;
    logic [1:0] w_done;
    logic [1:0] w_err;
    logic       w_act;

    uart_arb_chan u_rd (
        .clk      (clk),
        .rst      (rst),
        .req      ({bus.m1_rreq, bus.m0_rreq}),
        .size0    (bus.m0_rsize),
        .size1    (bus.m1_rsize),
        .bus_done (bus.rdone),
        .enable   (bus.renable),
        .size     (bus.rsize),
        .grant    (bus.rgrant),
        .done     (r_done),
        .err      (r_err),
        .active   (r_act)
    );

    uart_arb_chan u_wr (
        .clk      (clk),
        .rst      (rst),
        .req      ({bus.m1_wreq, bus.m0_wreq}),
        .size0    (bus.m0_wsize),
        .size1    (bus.m1_wsize),
        .bus_done (bus.wdone),
        .enable   (bus.wenable),
        .size     (bus.wsize),
        .grant    (bus.wgrant),
        .done     (w_done),
        .err      (w_err),
        .active   (w_act)
    );

    // Steer completions back to the owner; read data only on a real buffer done.
    always_comb begin
        bus.m0_rdone = r_done[0];
        bus.m1_rdone = r_done[1];
        bus.m0_rerr  = r_err[0];
        bus.m1_rerr  = r_err[1];
        bus.m0_rdata = (r_act && r_done[0]) ? bus.rdata : 32'h0;
        bus.m1_rdata = (r_act && r_done[1]) ? bus.rdata : 32'h0;
        bus.m0_wdone = w_done[0];
        bus.m1_wdone = w_done[1];
        bus.m0_werr  = w_err[0];
        bus.m1_werr  = w_err[1];
        bus.wdata    = w_act ? (bus.wgrant[1] ? bus.m1_wdata : bus.m0_wdata) : 32'h0;
    end
endmodule

// File: tb/tb_uart_port_arbiter.sv
// tb_uart_port_arbiter: directed checks of the UART port arbiter.
// Read-channel vector table plus write tie, reset and concurrency sequences.
module tb_uart_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    uart_port_arbiter_if bus ();

    uart_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        q0;
        logic [1:0]  s0;
        logic        q1;
        logic [1:0]  s1;
        logic        bd;
        logic [31:0] bdat;
        logic        ren;
        logic [1:0]  rsz;
        logic [1:0]  gnt;
        logic [1:0]  dn;
        logic [1:0]  er;
        logic [31:0] d0;
        logic [31:0] d1;
    } rvec_t;

    rvec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic serve_w(input logic [1:0] g);
        logic [31:0] dexp;
        dexp = g[1] ? 32'h12345678 : 32'hDEADBEEF;
        @(negedge clk); #1;
        chk("w_issue_grant", {30'd0, bus.wgrant}, {30'd0, g});
        chk("w_issue_en", {31'd0, bus.wenable}, 32'd1);
        chk("w_issue_data", bus.wdata, dexp);
        chk("w_issue_size", {30'd0, bus.wsize}, 32'd3);
        @(negedge clk);
        bus.wdone = 1'b1;
        #1;
        chk("w_wait_en", {31'd0, bus.wenable}, 32'd0);
        chk("w_done", {30'd0, bus.m1_wdone, bus.m0_wdone}, {30'd0, g});
        chk("w_err", {30'd0, bus.m1_werr, bus.m0_werr}, 32'd0);
        chk("w_wait_data", bus.wdata, dexp);
        @(negedge clk);
        bus.wdone = 1'b0;
        if (g[0]) bus.m0_wreq = 1'b0;
        else      bus.m1_wreq = 1'b0;
        #1;
        chk("w_idle_grant", {30'd0, bus.wgrant}, 32'd0);
        chk("w_idle_data", bus.wdata, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0,
                    1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0,
                    1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 32'h0, 32'h0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0,
                    1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 32'h0, 32'h0};
        tbl[3]  = '{1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 32'h41,
                    1'b0, 2'd0, 2'd1, 2'd1, 2'd0, 32'h41, 32'h0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h41,
                    1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 32'hFFFF,
                    1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 32'hFFFF,
                    1'b0, 2'd0, 2'd2, 2'd2, 2'd2, 32'h0, 32'h0};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0,
                    1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0};
        tbl[8]  = '{1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 32'h0,
                    1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0};
        tbl[9]  = '{1'b0, 2'd0, 1'b1, 2'd3, 1'b1, 32'h99,
                    1'b1, 2'd3, 2'd2, 2'd0, 2'd0, 32'h0, 32'h0};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 2'd3, 1'b1, 32'h12345678,
                    1'b0, 2'd3, 2'd2, 2'd2, 2'd0, 32'h0, 32'h12345678};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0,
                    1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0};

        bus.m0_rreq = 0; bus.m0_rsize = 0; bus.m1_rreq = 0; bus.m1_rsize = 0;
        bus.m0_wreq = 0; bus.m0_wsize = 0; bus.m0_wdata = 0;
        bus.m1_wreq = 0; bus.m1_wsize = 0; bus.m1_wdata = 0;
        bus.rdata = 0; bus.rdone = 0; bus.wdone = 0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_renable", {31'd0, bus.renable}, 32'd0);
        chk("rst_wenable", {31'd0, bus.wenable}, 32'd0);
        chk("rst_sizes", {28'd0, bus.rsize, bus.wsize}, 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_grants", {28'd0, bus.rgrant, bus.wgrant}, 32'd0);
        chk("rst_dones", {28'd0, bus.m0_rdone, bus.m1_rdone, bus.m0_wdone, bus.m1_wdone}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.m0_rreq = tbl[i].q0; bus.m0_rsize = tbl[i].s0;
            bus.m1_rreq = tbl[i].q1; bus.m1_rsize = tbl[i].s1;
            bus.rdone = tbl[i].bd; bus.rdata = tbl[i].bdat;
            #1;
            chk($sformatf("v%0d_renable", i), {31'd0, bus.renable}, {31'd0, tbl[i].ren});
            chk($sformatf("v%0d_rsize", i), {30'd0, bus.rsize}, {30'd0, tbl[i].rsz});
            chk($sformatf("v%0d_rgrant", i), {30'd0, bus.rgrant}, {30'd0, tbl[i].gnt});
            chk($sformatf("v%0d_rdone", i), {30'd0, bus.m1_rdone, bus.m0_rdone}, {30'd0, tbl[i].dn});
            chk($sformatf("v%0d_rerr", i), {30'd0, bus.m1_rerr, bus.m0_rerr}, {30'd0, tbl[i].er});
            chk($sformatf("v%0d_m0_rdata", i), bus.m0_rdata, tbl[i].d0);
            chk($sformatf("v%0d_m1_rdata", i), bus.m1_rdata, tbl[i].d1);
        end
        @(negedge clk);
        bus.rdone = 0; bus.rdata = 0;

        // Write ties: m0 first, then m1; solo m0; second tie.
        @(negedge clk);
        bus.m0_wsize = 2'd3; bus.m0_wdata = 32'hDEADBEEF;
        bus.m1_wsize = 2'd3; bus.m1_wdata = 32'h12345678;
        bus.m0_wreq = 1'b1; bus.m1_wreq = 1'b1;
        #1;
        chk("tie1_idle_en", {31'd0, bus.wenable}, 32'd0);
        serve_w(2'b01);
        serve_w(2'b10);
        @(negedge clk);
        bus.m0_wreq = 1'b1;
        serve_w(2'b01);
        @(negedge clk);
        bus.m0_wreq = 1'b1; bus.m1_wreq = 1'b1;
`ifdef UART_ARB_FIXED_PRIO_EN
        serve_w(2'b01);
        serve_w(2'b10);
`else
        serve_w(2'b10);
        serve_w(2'b01);
`endif

        // Reset in the middle of a read WAIT.
        @(negedge clk);
        bus.m0_rreq = 1'b1; bus.m0_rsize = 2'd0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("rstw_pre_grant", {30'd0, bus.rgrant}, 32'd1);
        #2;
        rst = 1'b1; bus.m0_rreq = 1'b0;
        #1;
        chk("rstw_grant", {30'd0, bus.rgrant}, 32'd0);
        chk("rstw_ren_size", {29'd0, bus.renable, bus.rsize}, 32'd0);
        @(negedge clk);
        rst = 1'b0; bus.rdone = 1'b1; bus.rdata = 32'h55;
        #1;
        chk("rstw_no_done", {31'd0, bus.m0_rdone}, 32'd0);
        chk("rstw_no_data", bus.m0_rdata, 32'd0);
        @(negedge clk);
        bus.rdone = 1'b0; bus.rdata = 0;

        // Concurrent m0 word read (slow buffer) and m1 byte write.
        @(negedge clk);
        bus.m0_rreq = 1'b1; bus.m0_rsize = 2'd3;
        bus.m1_wreq = 1'b1; bus.m1_wsize = 2'd0; bus.m1_wdata = 32'hA5;
        @(negedge clk); #1;
        chk("cc_grants", {28'd0, bus.rgrant, bus.wgrant}, {28'd0, 2'b01, 2'b10});
        chk("cc_enables", {30'd0, bus.renable, bus.wenable}, 32'd3);
        chk("cc_wdata", bus.wdata, 32'hA5);
        @(negedge clk);
        bus.wdone = 1'b1;
        #1;
        chk("cc_wdone", {31'd0, bus.m1_wdone}, 32'd1);
        chk("cc_grants_wait", {28'd0, bus.rgrant, bus.wgrant}, {28'd0, 2'b01, 2'b10});
        chk("cc_rsize_1", {30'd0, bus.rsize}, 32'd3);
        @(negedge clk);
        bus.wdone = 1'b0; bus.m1_wreq = 1'b0;
        #1;
        chk("cc_wgrant_idle", {30'd0, bus.wgrant}, 32'd0);
        chk("cc_rsize_2", {30'd0, bus.rsize}, 32'd3);
        for (int i = 3; i < 20; i++) begin
            @(negedge clk); #1;
            chk($sformatf("cc_rsize_%0d", i), {30'd0, bus.rsize}, 32'd3);
            chk($sformatf("cc_nodone_%0d", i), {31'd0, bus.m0_rdone}, 32'd0);
        end
        @(negedge clk);
        bus.rdone = 1'b1; bus.rdata = 32'hCAFEF00D;
        #1;
        chk("cc_rdone", {31'd0, bus.m0_rdone}, 32'd1);
        chk("cc_rdata", bus.m0_rdata, 32'hCAFEF00D);
        @(negedge clk);
        bus.rdone = 1'b0; bus.m0_rreq = 1'b0;
        #1;
        chk("cc_rgrant_idle", {30'd0, bus.rgrant}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_port_arbiter.md
# uart_port_arbiter

- Shares the single read port and single write port of the UART byte/word buffer between two requesters: m0 (core load/store unit) and m1 (program loader / debug monitor).
- The read and write channels are arbitrated independently, each by its own small state machine with a round-robin grant.
- The arbiter holds the buffer's size and data inputs stable until the buffer completes the transfer.
- It intercepts illegal sizes so the buffer never stalls forever.

## Interface
Parameters:
- none

Ports (N ∈ {0,1}; every `mN_` line exists once per requester):
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mN_rreq` in 1: read request level. Held with `mN_rsize` stable until `mN_rdone`.
- `mN_rsize` in 2: read size. `2'b00` = byte, `2'b11` = word. Any other value is illegal.
- `mN_rdone` out 1: one-cycle read completion.
- `mN_rdata` out 32: read data, valid only while `mN_rdone` = 1, otherwise 0.
- `mN_rerr` out 1: pulses with `mN_rdone` when the size was illegal.
- `mN_wreq` in 1: write request level. Held with `mN_wsize` and `mN_wdata` stable until `mN_wdone`.
- `mN_wsize` in 2 / `mN_wdata` in 32: write size (same encoding as reads) and write data.
- `mN_wdone` out 1 / `mN_werr` out 1: write completion and illegal-size flag.
- `renable` out 1 / `rsize` out 2 / `rdata` in 32 / `rdone` in 1: buffer read port.
- `wenable` out 1 / `wsize` out 2 / `wdata` out 32 / `wdone` in 1: buffer write port.
- `rgrant` out 2 / `wgrant` out 2: one-hot current owner, or 0 when idle.

## Operation
Each channel (read shown; write is identical with w-signals) has states IDLE, ISSUE, WAIT.

- **IDLE:** if any `mN_rreq` is high, grant one requester, latch its index into `rgrant`, and move to ISSUE.
  - Only one requester asking: that requester wins.
  - Both asking: the requester not served last wins.
  - The round-robin pointer resets to "m1 served last", so m0 wins the first tie.
- **ISSUE:** lasts one cycle.
  - Legal size: drive `renable` = 1 and `rsize` from the owner, then go to WAIT.
  - Illegal size: drive no `renable`, pulse `mN_rdone` and `mN_rerr` with `mN_rdata` = 0, then go to IDLE.
- **WAIT:** keep `renable` = 0 and hold `rsize` at the owner's size, because the buffer re-samples size on its internal retries.
  - When `rdone` = 1: `mN_rdone` = 1 (combinational, gated by grant), `mN_rdata` = `rdata`. Advance the pointer and go to IDLE.
- Write channel: `wdata` and `wsize` come from the owner throughout ISSUE and WAIT.
- Outside ISSUE/WAIT, `wdata` = 0 and `wsize` = 0.
- Requester dropping its request mid-transaction: not legal. The arbiter still completes the transfer and still pulses done.
- Read and write may be simultaneously granted to the same or different requesters.
- `rdone`/`wdone` arriving while IDLE/ISSUE: ignored.

## Timing
- Reset (asynchronous): both channels go to IDLE.
  - Outputs: `renable` = `wenable` = 0, `rsize` = `wsize` = 0, `wdata` = 0, `rgrant` = `wgrant` = 0.
  - All `mN_*done`, `mN_*err` and `mN_rdata` = 0; pointers = m1.
- Reset mid-transaction abandons the transfer. No done is issued.
- Request seen in cycle c → ISSUE at c+1 (`renable` high in c+1 only). Minimum done in c+2 when the buffer answers immediately.
- Done is seen by the requester in the same cycle as buffer `rdone`/`wdone`. The requester deasserts its request at the next edge. The channel is IDLE in the following cycle and samples the new request level, so no double grant occurs.
- Back-to-back throughput: one transfer per 3 cycles per channel minimum. WAIT is unbounded (buffer empty/full).
- Illegal size: done+err in c+1.

## Configuration
- `UART_ARB_FIXED_PRIO_EN`
  - Defined: m0 always wins ties (fixed priority); the pointer logic is removed.
  - Undefined (default): round-robin as above.

## Test plan
- Reset mid-WAIT: assert `rst` for 1 cycle → all outputs 0 immediately. No `m0_rdone` follows, even if `rdone` arrives next cycle.
- m0 byte read, buffer returns `rdone` with `rdata` = 32'h0000_0041 two cycles after `renable` → `m0_rdone` for exactly 1 cycle with `m0_rdata` = 32'h41. `rsize` holds 2'b00 throughout WAIT.
- m0 and m1 both hold word writes (`wdata` = 32'hDEADBEEF / 32'h12345678) from the same cycle:
  - Default: m0 is served first, then m1.
  - Next tie after that: m1 is served before m0 (default build).
  - With `UART_ARB_FIXED_PRIO_EN`: m0 first on every tie.
- `m1_rsize` = 2'b01 → `m1_rdone` = `m1_rerr` = 1 one cycle after the request, `renable` never asserted, `m1_rdata` = 0.
- Simultaneous m0 read and m1 write with the buffer delaying `rdone` 20 cycles:
  - The write completes independently.
  - `rgrant` = 2'b01 and `wgrant` = 2'b10 concurrently.
  - `rsize` stays stable for all 20 cycles.
